// File: rtl/fp32_pkg.sv
// FP32 field layout and special-value constants shared by the adder datapath
// and the streaming 32-operand reduction top.
package fp32_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;
  localparam int EXP_W    = EXP_MSB - EXP_LSB + 1;
  localparam int MAN_W    = MAN_MSB + 1;
  localparam int EXP_BIAS = 127;

  // All-ones exponent marks Inf/NaN; any rounded exponent reaching it overflows.
  localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * EXP_BIAS + 1);

  localparam logic [31:0] FP32_ZERO     = 32'h0000_0000;
  localparam logic [31:0] FP32_NEG_ZERO = 32'h8000_0000;
  localparam logic [31:0] FP32_POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] FP32_NEG_INF  = 32'hFF80_0000;
  localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;

endpackage

// File: rtl/fp32_add.sv
// Combinational FP32 adder: flush-to-zero inputs and results, round-to-nearest-even,
// canonical NaN, saturating exponent overflow to signed infinity.
import fp32_pkg::*;

module fp32_add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  logic             a_sign, b_sign, big_sign, eff_sub;
  logic [EXP_W-1:0] a_exp, b_exp, big_exp, small_exp, exp_diff;
  logic [MAN_W-1:0] a_man, b_man, big_man, small_man, rnd_man;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [4:0]       shamt, lz;
  logic [26:0]      big_ext, small_ext, small_al, norm;
  logic [53:0]      small_wide;
  logic [27:0]      mag;
  logic signed [9:0] norm_exp, rnd_exp;
  logic             round_up;
  logic [24:0]      m25;

  assign a_sign = a[SIGN_BIT];
  assign b_sign = b[SIGN_BIT];
  assign a_exp  = a[EXP_MSB:EXP_LSB];
  assign b_exp  = b[EXP_MSB:EXP_LSB];
  assign a_man  = a[MAN_MSB:0];
  assign b_man  = b[MAN_MSB:0];

  // A zero exponent covers both true zeros and subnormals, which are flushed.
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == EXP_MAX) && (a_man == '0);
  assign b_inf  = (b_exp == EXP_MAX) && (b_man == '0);
  assign a_nan  = (a_exp == EXP_MAX) && (a_man != '0);
  assign b_nan  = (b_exp == EXP_MAX) && (b_man != '0);

  always_comb begin
    if ({b_exp, b_man} > {a_exp, a_man}) begin
      big_sign = b_sign; big_exp = b_exp; big_man = b_man;
      small_exp = a_exp; small_man = a_man;
    end else begin
      big_sign = a_sign; big_exp = a_exp; big_man = a_man;
      small_exp = b_exp; small_man = b_man;
    end
    eff_sub   = a_sign ^ b_sign;
    exp_diff  = big_exp - small_exp;
    shamt     = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
    big_ext   = {1'b1, big_man, 3'b000};
    small_ext = {1'b1, small_man, 3'b000};
    // Bits shifted past the round position collapse into a sticky LSB.
    small_wide = {small_ext, 27'd0} >> shamt;
    small_al   = small_wide[53:27] | {26'd0, |small_wide[26:0]};
    mag = eff_sub ? ({1'b0, big_ext} - {1'b0, small_al})
                  : ({1'b0, big_ext} + {1'b0, small_al});

    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (mag[i]) lz = 5'(26 - i);
    end
    if (mag[27]) begin
      norm     = {mag[27:2], mag[1] | mag[0]};
      norm_exp = $signed({2'b00, big_exp}) + 10'sd1;
    end else begin
      norm     = mag[26:0] << lz;
      norm_exp = $signed({2'b00, big_exp}) - $signed({5'b00000, lz});
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    m25      = {1'b0, norm[26:3]} + {24'd0, round_up};
    rnd_exp  = m25[24] ? (norm_exp + 10'sd1) : norm_exp;
    rnd_man  = m25[24] ? m25[23:1] : m25[22:0];
  end

  always_comb begin
    sum = FP32_QNAN;
    if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
      sum = FP32_QNAN;
    end else if (a_inf) begin
      sum = a_sign ? FP32_NEG_INF : FP32_POS_INF;
    end else if (b_inf) begin
      sum = b_sign ? FP32_NEG_INF : FP32_POS_INF;
    end else if (a_zero && b_zero) begin
      sum = (a_sign && b_sign) ? FP32_NEG_ZERO : FP32_ZERO;
    end else if (a_zero) begin
      sum = b;
    end else if (b_zero) begin
      sum = a;
    end else if ((mag == '0) || (norm_exp <= 10'sd0)) begin
      sum = FP32_ZERO;
    end else if (rnd_exp >= $signed({2'b00, EXP_MAX})) begin
      sum = big_sign ? FP32_NEG_INF : FP32_POS_INF;
    end else begin
      sum = {big_sign, rnd_exp[7:0], rnd_man};
    end
  end

endmodule

// File: rtl/fp32_adder_32_input_pipeline.sv
// Streaming reduction: sums each group of N_INPUTS accepted FP32 operands in strict
// sequential order and strobes o_valid with the registered group sum.
import fp32_pkg::*;

module fp32_adder_32_input_pipeline #(
  parameter int N_INPUTS   = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
);

  localparam int CNT_W = $clog2(N_INPUTS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);

  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, o_data_q, o_data_d, sum_next;
  logic                  o_valid_q, o_valid_d;

  fp32_add u_add (
    .a   (acc_q),
    .b   (i_data),
    .sum (sum_next)
  );

  // The accumulator restarts from +0 on the same edge that publishes a group sum,
  // so the next group's first operand is accepted without a bubble.
  always_comb begin
    count_d   = count_q;
    acc_d     = acc_q;
    o_data_d  = o_data_q;
    o_valid_d = 1'b0;
    if (i_valid) begin
      if (count_q == LAST_IDX) begin
        o_data_d  = sum_next;
        o_valid_d = 1'b1;
        acc_d     = FP32_ZERO;
        count_d   = '0;
      end else begin
        acc_d   = sum_next;
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      count_q   <= '0;
      acc_q     <= FP32_ZERO;
      o_data_q  <= FP32_ZERO;
      o_valid_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      acc_q     <= acc_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_fp32_adder_32_input_pipeline.sv
// Directed group table, back-to-back/gap/reset sequences, and random groups checked
// against a double-precision reference with explicit RNE rounding to FP32.
module tb_fp32_adder_32_input_pipeline;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_data;
  logic [31:0] o_data;
  logic        o_valid;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int last_pulse_cycle = 0;
  int first_pulse_cycle = 0;
  logic [31:0] group_ops [32];

  typedef struct {
    string       name;
    logic [31:0] even_op;
    logic [31:0] odd_op;
    int          idx1;
    logic [31:0] op1;
    int          idx2;
    logic [31:0] op2;
    logic [31:0] expected;
  } group_vec_t;

  group_vec_t vecs [12];

  fp32_adder_32_input_pipeline #(.N_INPUTS(32), .DATA_WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_data  (o_data),
    .o_valid (o_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Converts a normal FP32 pattern to a real by re-biasing the exponent into double format.
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = 11'(f[30:23]) + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  // Rounds a real (known to be in FP32 normal range) to FP32 with round-to-nearest-even.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] bits;
    logic [7:0]  fe;
    logic [24:0] m;
    bits = $realtobits(r);
    fe   = 8'(bits[62:52] - 11'd896);
    m    = {2'b01, bits[51:29]};
    if (bits[28] && ((|bits[27:0]) || m[0])) m = m + 25'd1;
    if (m[24]) begin
      fe = fe + 8'd1;
      m  = m >> 1;
    end
    return {bits[63], fe, m[22:0]};
  endfunction

  // Double sum is exact when exponents differ by at most 28; beyond that the
  // smaller operand is below half an ulp of the larger and cannot change it.
  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    int  ea, eb;
    real s;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0) return b;
    if (eb == 0) return a;
    if (ea > eb + 28) return a;
    if (eb > ea + 28) return b;
    s = f2r(a) + f2r(b);
    if (s == 0.0) return 32'h0000_0000;
    return r2f(s);
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] d);
    i_valid = v;
    i_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  // Feeds group_ops as one group, optionally with idle gaps carrying junk data.
  task automatic feedGroup(input string name, input logic [31:0] expected, input bit gaps);
    logic early;
    early = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        applyStimulus(1'b0, 32'h7F80_0001);
        if (o_valid) early = 1'b1;
      end
      applyStimulus(1'b1, group_ops[i]);
      if (i < 31 && o_valid) early = 1'b1;
    end
    if (o_valid) last_pulse_cycle = cycle;
    checkOutput({name, " early_pulse"}, {31'd0, early}, 32'd0);
    checkOutput({name, " o_valid"}, {31'd0, o_valid}, 32'd1);
    checkOutput({name, " o_data"}, o_data, expected);
  endtask

  initial begin
    vecs[0]  = '{"ones",          32'h3F800000, 32'h3F800000, -1, 32'h0,        -1, 32'h0,        32'h42000000};
    vecs[1]  = '{"alt_pm1",       32'h3F800000, 32'hBF800000, -1, 32'h0,        -1, 32'h0,        32'h00000000};
    vecs[2]  = '{"one_inf",       32'h3F800000, 32'h3F800000,  5, 32'h7F800000, -1, 32'h0,        32'h7F800000};
    vecs[3]  = '{"inf_minus_inf", 32'h3F800000, 32'h3F800000,  3, 32'h7F800000, 20, 32'hFF800000, 32'h7FC00000};
    vecs[4]  = '{"nan_input",     32'h3F800000, 32'h3F800000, 10, 32'h7F800001, -1, 32'h0,        32'h7FC00000};
    vecs[5]  = '{"ones_after_nan",32'h3F800000, 32'h3F800000, -1, 32'h0,        -1, 32'h0,        32'h42000000};
    vecs[6]  = '{"neg_inf_last",  32'h3F800000, 32'h3F800000, 31, 32'hFF800000, -1, 32'h0,        32'hFF800000};
    vecs[7]  = '{"overflow",      32'h7F000000, 32'h7F000000, -1, 32'h0,        -1, 32'h0,        32'h7F800000};
    vecs[8]  = '{"neg_zero",      32'h80000000, 32'h80000000, -1, 32'h0,        -1, 32'h0,        32'h00000000};
    vecs[9]  = '{"subnormal",     32'h00000001, 32'h80000001, -1, 32'h0,        -1, 32'h0,        32'h00000000};
    vecs[10] = '{"rne_tie",       32'h33800000, 32'h33800000,  0, 32'h3F800000, -1, 32'h0,        32'h3F800000};
    vecs[11] = '{"exact_ulps",    32'h34000000, 32'h34000000,  0, 32'h3F800000, -1, 32'h0,        32'h3F80001F};

    // Reset state with valid data present: nothing may be accepted.
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h3F800000);
    applyStimulus(1'b1, 32'h3F800000);
    checkOutput("reset o_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("reset o_data", o_data, 32'h0);
    rst_n = 1'b0;

    // Directed groups back-to-back, no idle cycles.
    foreach (vecs[v]) begin
      for (int i = 0; i < 32; i++) begin
        group_ops[i] = (i % 2 == 0) ? vecs[v].even_op : vecs[v].odd_op;
        if (i == vecs[v].idx1) group_ops[i] = vecs[v].op1;
        if (i == vecs[v].idx2) group_ops[i] = vecs[v].op2;
      end
      feedGroup(vecs[v].name, vecs[v].expected, 1'b0);
    end

    // 1.0..32.0 twice; pulses must be exactly 32 cycles apart.
    for (int i = 0; i < 32; i++) group_ops[i] = r2f(real'(i + 1));
    feedGroup("ramp_a", 32'h44040000, 1'b0);
    first_pulse_cycle = last_pulse_cycle;
    feedGroup("ramp_b", 32'h44040000, 1'b0);
    checkOutput("ramp pulse spacing", 32'(last_pulse_cycle - first_pulse_cycle), 32'd32);

    // Alternating +/-1 with random idle gaps.
    for (int i = 0; i < 32; i++) group_ops[i] = (i % 2 == 0) ? 32'h3F800000 : 32'hBF800000;
    feedGroup("alt_gaps", 32'h00000000, 1'b1);

    // Partial group discarded by reset.
    for (int i = 0; i < 32; i++) group_ops[i] = 32'h3F800000;
    feedGroup("pre_reset", 32'h42000000, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'h3F800000);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h3F800000);
    checkOutput("mid_reset o_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("mid_reset o_data", o_data, 32'h0);
    rst_n = 1'b0;
    feedGroup("post_reset", 32'h42000000, 1'b0);

    // Random normal operands against the reference model.
    for (int g = 0; g < 1000; g++) begin
      logic [31:0] acc;
      acc = 32'h0;
      for (int i = 0; i < 32; i++) begin
        group_ops[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
        acc = model_add(acc, group_ops[i]);
      end
      feedGroup($sformatf("rand%0d", g), acc, 1'b0);
    end

    applyStimulus(1'b0, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
